// File: rtl/alu_multicycle_if.sv
// ============================================================================
// alu_multicycle_if : command/result handshake bundle for alu_multicycle
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_multicycle_if #(
  parameter int WIDTH   = 32,
  parameter int CMD_LEN = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [CMD_LEN-1:0] alu_cmd;
  logic [WIDTH-1:0]   alu_in1;
  logic [WIDTH-1:0]   alu_in2;
  logic               set_flags;
  logic               cin;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   alu_out;
  logic [3:0]         status_reg;
  logic               busy;

  modport master (
    output in_valid, alu_cmd, alu_in1, alu_in2, set_flags, cin, out_ready,
    input  in_ready, out_valid, alu_out, status_reg, busy
  );

  modport slave (
    input  in_valid, alu_cmd, alu_in1, alu_in2, set_flags, cin, out_ready,
    output in_ready, out_valid, alu_out, status_reg, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ============================================================================
// alu_multicycle : execute-stage ALU, registered result, iterative shift-add MUL
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int CMD_LEN = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  alu_multicycle_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;

  localparam logic [CMD_LEN-1:0] OP_MOV  = CMD_LEN'(4'h1);
  localparam logic [CMD_LEN-1:0] OP_ADD  = CMD_LEN'(4'h2);
  localparam logic [CMD_LEN-1:0] OP_ADC  = CMD_LEN'(4'h3);
  localparam logic [CMD_LEN-1:0] OP_SUB  = CMD_LEN'(4'h4);
  localparam logic [CMD_LEN-1:0] OP_SBC  = CMD_LEN'(4'h5);
  localparam logic [CMD_LEN-1:0] OP_AND  = CMD_LEN'(4'h6);
  localparam logic [CMD_LEN-1:0] OP_ORR  = CMD_LEN'(4'h7);
  localparam logic [CMD_LEN-1:0] OP_EOR  = CMD_LEN'(4'h8);
  localparam logic [CMD_LEN-1:0] OP_MVN  = CMD_LEN'(4'h9);
  localparam logic [CMD_LEN-1:0] OP_MUL  = CMD_LEN'(4'hA);
  localparam logic [CMD_LEN-1:0] OP_ADDR = CMD_LEN'(4'hB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               mul_sf_q, mul_sf_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic [3:0]         status_q, status_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH:0]     add_sum, sub_sum;
  logic [WIDTH-1:0]   op_res;
  logic               op_c, op_v, op_wr;
  logic               in_ready_w, accept_w;

  assign op_a = bus.alu_in1;
  assign op_b = bus.alu_in2;

  // Single-cycle datapath; status packing is {Z,C,N,V}.
  always_comb begin
    add_sum = {1'b0, op_a} + {1'b0, op_b}
            + (WIDTH+1)'(bus.alu_cmd == OP_ADC && bus.cin);
    // Subtract as A + ~B + carry: carry is 1 for SUB, cin for SBC.
    sub_sum = {1'b0, op_a} + {1'b0, ~op_b}
            + (WIDTH+1)'(bus.alu_cmd == OP_SUB || (bus.alu_cmd == OP_SBC && bus.cin));
    op_res  = '0;
    op_c    = status_q[2];
    op_v    = status_q[0];
    op_wr   = 1'b1;
    case (bus.alu_cmd)
      OP_MOV: op_res = op_b;
      OP_MVN: op_res = ~op_b;
      OP_ADD, OP_ADC: begin
        op_res = add_sum[WIDTH-1:0];
        op_c   = add_sum[WIDTH];
        op_v   = (op_a[MSB] == op_b[MSB]) && (op_res[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        op_res = sub_sum[WIDTH-1:0];
        op_c   = sub_sum[WIDTH];
        op_v   = (op_a[MSB] != op_b[MSB]) && (op_res[MSB] != op_a[MSB]);
      end
      OP_AND:  op_res = op_a & op_b;
      OP_ORR:  op_res = op_a | op_b;
      OP_EOR:  op_res = op_a ^ op_b;
      OP_ADDR: begin
        op_res = add_sum[WIDTH-1:0];
        op_wr  = 1'b0;
      end
      default: op_wr = 1'b0;
    endcase
  end

  assign in_ready_w = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_w   = bus.in_valid && in_ready_w;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_sf_d    = mul_sf_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    status_d    = status_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          if (bus.alu_cmd == OP_MUL) begin
            state_d  = S_MUL;
            mul_a_d  = op_a;
            mul_b_d  = op_b;
            mul_sf_d = bus.set_flags;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            alu_out_d   = op_res;
            out_valid_d = 1'b1;
            if (bus.set_flags && op_wr) begin
              status_d = {op_res == '0, op_c, op_res[MSB], op_v};
            end
          end
        end
      end
      S_MUL: begin
        if (mul_b_q[cnt_q]) begin
          acc_d = acc_q + (mul_a_q << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        alu_out_d   = acc_q;
        out_valid_d = 1'b1;
        if (mul_sf_q) begin
          status_d = {acc_q == '0, status_q[2], acc_q[MSB], status_q[0]};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_sf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      status_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_sf_q    <= mul_sf_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      status_q    <= status_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_out    = alu_out_q;
  assign bus.status_reg = status_q;
  assign bus.busy       = (state_q == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ============================================================================
// tb_alu_multicycle : directed + randomized bench against a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_multicycle;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W), .CMD_LEN(4)) bus ();

  alu_multicycle #(.WIDTH(W), .CMD_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit rnd_or = 1'b0;
  bit chk_on = 1'b0;

  // Model: pending result, committed flags, cycles left until a MUL result appears.
  bit          m_ov      = 1'b0;
  logic [31:0] m_out     = '0;
  logic [3:0]  m_st      = '0;
  int          m_left    = 0;
  logic [31:0] m_mul_res = '0;
  bit          m_mul_s   = 1'b0;
  bit          m_acc;
  logic [31:0] m_r;
  logic [3:0]  m_s;
  bit          m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [3:0] old,
                         output logic [31:0] res, output logic [3:0] st, output bit wr);
    longint ua, ub, sa, sb, full, sres, bi, cc;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cc = (cmd == 4'd3 && ci) ? 1 : 0;
    c = old[2];
    v = old[0];
    wr = 1'b1;
    res = '0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3, 4'd11: begin
        full = ua + ub + cc;
        res  = full[31:0];
        c    = full[32];
        sres = sa + sb + cc;
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        if (cmd == 4'd11) wr = 1'b0;
      end
      4'd4, 4'd5: begin
        bi   = (cmd == 4'd5 && !ci) ? 1 : 0;
        full = ua - ub - bi;
        res  = full[31:0];
        c    = (ua >= ub + bi);
        sres = sa - sb - bi;
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd6:  res = a & b;
      4'd7:  res = a | b;
      4'd8:  res = a ^ b;
      4'd10: res = a * b;
      default: wr = 1'b0;
    endcase
    st = {res == 32'd0, c, res[31], v};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov   = 1'b0;
      m_out  = '0;
      m_st   = '0;
      m_left = 0;
    end else begin
      m_acc = bus.in_valid && (m_left == 0) && (!m_ov || bus.out_ready);
      if (m_ov && bus.out_ready) m_ov = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ov  = 1'b1;
          m_out = m_mul_res;
          if (m_mul_s) m_st = {m_mul_res == 32'd0, m_st[2], m_mul_res[31], m_st[0]};
        end
      end else if (m_acc) begin
        ref_alu(bus.alu_cmd, bus.alu_in1, bus.alu_in2, bus.cin, m_st, m_r, m_s, m_wr);
        if (bus.alu_cmd == 4'd10) begin
          m_left    = W + 1;
          m_mul_res = m_r;
          m_mul_s   = bus.set_flags;
        end else begin
          m_ov  = 1'b1;
          m_out = m_r;
          if (bus.set_flags && m_wr) m_st = m_s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("busy", 32'(bus.busy), 32'(m_left >= 2));
      chk("status", 32'(bus.status_reg), 32'(m_st));
      if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(m_left == 0 && (!m_ov || bus.out_ready)));
      if (m_ov) chk("alu_out", bus.alu_out, m_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rnd_or) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c);
    bit ok;
    ok = 1'b0;
    bus.alu_cmd   = cmd;
    bus.alu_in1   = a;
    bus.alu_in2   = b;
    bus.set_flags = s;
    bus.cin       = c;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready 0 expected accept within 200 cycles");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] orr_a [4] = '{32'h0000_00F0, 32'h1200_0000, 32'h0000_0000, 32'h8000_0000};
  logic [31:0] orr_b [4] = '{32'h0000_000F, 32'h0034_0000, 32'h0000_0000, 32'h0000_0001};
  logic [31:0] orr_r [4] = '{32'h0000_00FF, 32'h1234_0000, 32'h0000_0000, 32'h8000_0001};

  initial begin
    int lat, nb, nr, nov;
    bus.in_valid  = 1'b0;
    bus.alu_cmd   = '0;
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    bus.set_flags = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_status", 32'(bus.status_reg), 32'd0);
    chk("rst_alu_out", bus.alu_out, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk_on = 1'b1;
    bus.out_ready = 1'b1;

    // ADD overflow into the sign bit
    issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_out", bus.alu_out, 32'h8000_0000);
    chk("add_flags", 32'(bus.status_reg), 32'(4'b0011));
    chk("model_add_out", m_out, 32'h8000_0000);
    chk("model_add_flags", 32'(m_st), 32'(4'b0011));
    step();

    issue(4'd4, 32'd5, 32'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("sub_out", bus.alu_out, 32'd0);
    chk("sub_flags", 32'(bus.status_reg), 32'(4'b1100));
    chk("model_sub_flags", 32'(m_st), 32'(4'b1100));
    step();
    issue(4'd3, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("adc_out", bus.alu_out, 32'd1);
    chk("adc_flags_kept", 32'(bus.status_reg), 32'(4'b1100));
    step();

    // Iterative multiply latency and stall
    issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0);
    lat = -1; nb = 0; nr = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      if (bus.busy) nb++;
      if (bus.in_ready) nr++;
    end
    chk("mul_latency", 32'(lat), 32'd33);
    chk("mul_busy_cycles", 32'(nb), 32'd32);
    chk("mul_in_ready_high", 32'(nr), 32'd0);
    chk("mul_out", bus.alu_out, 32'hFFFF_FFFF);
    chk("model_mul_out", m_out, 32'hFFFF_FFFF);
    step();

    // Backpressure: result must hold for 3 cycles
    bus.out_ready = 1'b0;
    issue(4'd2, 32'd3, 32'd4, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out", bus.alu_out, 32'd7);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    @(negedge clk);
    chk("bp_taken", 32'(bus.out_valid), 32'd0);
    step();

    // Back-to-back ORR stream
    for (int k = 0; k < 4; k++) begin
      bus.alu_cmd   = 4'd7;
      bus.alu_in1   = orr_a[k];
      bus.alu_in2   = orr_b[k];
      bus.set_flags = 1'b0;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      chk("stream_ready", 32'(bus.in_ready), 32'd1);
      if (k > 0) begin
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_out", bus.alu_out, orr_r[k-1]);
      end
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 32'(bus.out_valid), 32'd1);
    chk("stream_last_out", bus.alu_out, orr_r[3]);
    chk("stream_flags_kept", 32'(bus.status_reg), 32'(4'b1100));
    step();

    // Reset in the middle of a multiply
    issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    chk("rr_busy_before", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rr_busy", 32'(bus.busy), 32'd0);
    chk("rr_status", 32'(bus.status_reg), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    nov = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) nov++;
    end
    chk("rr_no_stale_output", 32'(nov), 32'd0);
    step();

    // Randomized traffic with random consumer backpressure
    rnd_or = 1'b1;
    for (int t = 0; t < 300; t++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_or = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) step();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
